gpio_in_filter: RTL and testbench

//  Input conditioning stage between the board GPIO pin mapping and the core's pin_in bus.

---
 rtl/gpio_in_filter_pkg.sv | 17 +
 rtl/gpio_in_filter_pin_filter.sv | 84 ++++++++
 rtl/gpio_in_filter.sv | 85 ++++++++
 tb/tb_gpio_in_filter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_in_filter_pkg.sv
// Shared constants and width helpers for the GPIO input conditioning stage.
// Used by gpio_in_filter (GPIO_IN_FILTER_EN selects the glitch filter) and pin_filter.
package gpio_in_pkg;

  // Pads idle high, so the synchroniser and pin_in start at 1.
  localparam logic INIT_IDLE_HIGH = 1'b1;

  function automatic int tick_w(input int tick_div);
    return (tick_div > 1) ? $clog2(tick_div) : 1;
  endfunction

  // The per-pin counter only has to hold 0..filter_len-1.
  function automatic int cnt_w(input int filter_len);
    return (filter_len > 1) ? $clog2(filter_len) : 1;
  endfunction

endpackage

// File: rtl/gpio_in_filter_pin_filter.sv
// One pin's consecutive-agreement filter plus registered rise/fall strobes.
// With GPIO_IN_FILTER_EN undefined the pin simply follows the synchroniser output.
module pin_filter
  import gpio_in_pkg::*;
#(
  parameter int   FILTER_LEN = 3,
  parameter logic INIT_VAL   = INIT_IDLE_HIGH
) (
  input  logic clock,
  input  logic resn,
  input  logic s,
  input  logic tick,
  input  logic bypass,
  output logic pin,
  output logic rise,
  output logic fall
);

  logic pin_q;
  logic pin_nxt;
  logic rise_q;
  logic fall_q;

`ifdef GPIO_IN_FILTER_EN
  localparam int CW = cnt_w(FILTER_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Any sample that agrees with the held level restarts the count.
  always_comb begin
    pin_nxt = pin_q;
    cnt_nxt = cnt;
    if (bypass) begin
      pin_nxt = s;
      cnt_nxt = '0;
    end else if (tick) begin
      if (s == pin_q) begin
        cnt_nxt = '0;
      end else if (cnt == CNT_LAST) begin
        pin_nxt = s;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
`else
  localparam int unused_len = FILTER_LEN;
  logic unused_ctrl;
  assign unused_ctrl = tick ^ bypass;

  always_comb begin
    pin_nxt = s;
  end
`endif

  // Strobes are registered with pin_q so they line up with the level change.
  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      pin_q  <= INIT_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      pin_q  <= pin_nxt;
      rise_q <= pin_nxt & ~pin_q;
      fall_q <= ~pin_nxt & pin_q;
    end
  end

  assign pin  = pin_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: per-pin synchroniser, shared sample tick, per-pin filter and edge strobes.
// Define GPIO_IN_FILTER_EN to build the tick counter, glitch filter and bypass control.
module gpio_in_filter
  import gpio_in_pkg::*;
#(
  parameter int               NPINS       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter int               TICK_DIV    = 16,
  parameter int               FILTER_LEN  = 3,
  parameter logic [NPINS-1:0] INIT        = {NPINS{INIT_IDLE_HIGH}}
) (
  input  logic             clock,
  input  logic             resn,
  input  logic [NPINS-1:0] pin_raw,
  input  logic             bypass,
  output logic [NPINS-1:0] pin_in,
  output logic [NPINS-1:0] pin_rise,
  output logic [NPINS-1:0] pin_fall,
  output logic             tick
);

  logic [NPINS-1:0] sync_q [SYNC_STAGES];
  logic [NPINS-1:0] s;

  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= INIT;
      end
    end else begin
      sync_q[0] <= pin_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IN_FILTER_EN
  localparam int TW = tick_w(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_cnt_nxt;
  logic          tick_q;

  always_comb begin
    tick_cnt_nxt = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
  end

  // tick_q is high exactly while tick_cnt == TICK_LAST, but stays low in reset even for TICK_DIV=1.
  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_cnt <= tick_cnt_nxt;
      tick_q   <= (tick_cnt_nxt == TICK_LAST);
    end
  end

  assign tick = tick_q;
`else
  localparam int unused_div = TICK_DIV;
  assign tick = 1'b0;
`endif

  for (genvar g = 0; g < NPINS; g++) begin : g_pin
    pin_filter #(
      .FILTER_LEN (FILTER_LEN),
      .INIT_VAL   (INIT[g])
    ) u_pin_filter (
      .clock  (clock),
      .resn   (resn),
      .s      (s[g]),
      .tick   (tick),
      .bypass (bypass),
      .pin    (pin_in[g]),
      .rise   (pin_rise[g]),
      .fall   (pin_fall[g])
    );
  end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter (NPINS=32, SYNC_STAGES=2, TICK_DIV=4, FILTER_LEN=3).
// Scenario set follows whether GPIO_IN_FILTER_EN is defined for the build.
module tb_gpio_in_filter;

  logic        clock = 1'b0;
  logic        resn  = 1'b0;
  logic [31:0] pin_raw = '1;
  logic        bypass  = 1'b0;
  logic [31:0] pin_in;
  logic [31:0] pin_rise;
  logic [31:0] pin_fall;
  logic        tick;

  int n_pass  = 0;
  int n_total = 0;

  gpio_in_filter #(
    .NPINS       (32),
    .SYNC_STAGES (2),
    .TICK_DIV    (4),
    .FILTER_LEN  (3)
  ) dut (
    .clock    (clock),
    .resn     (resn),
    .pin_raw  (pin_raw),
    .bypass   (bypass),
    .pin_in   (pin_in),
    .pin_rise (pin_rise),
    .pin_fall (pin_fall),
    .tick     (tick)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic exp_tick;
    resn    = 1'b0;
    pin_raw = '1;
    bypass  = 1'b0;
    repeat (3) step();
    n_total++;
    if (pin_in !== 32'hFFFF_FFFF) $display("FAIL reset_pin_in actual=%h required=ffffffff", pin_in);
    else n_pass++;
    n_total++;
    if ((pin_rise | pin_fall) !== 32'h0) $display("FAIL reset_strobes actual=%h/%h required=0", pin_rise, pin_fall);
    else n_pass++;
    n_total++;
    if (tick !== 1'b0) $display("FAIL reset_tick actual=%b required=0", tick);
    else n_pass++;
    resn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
`ifdef GPIO_IN_FILTER_EN
      exp_tick = ((k % 4) == 3);
`else
      exp_tick = 1'b0;
`endif
      n_total++;
      if (tick !== exp_tick) $display("FAIL release_tick cycle=%0d actual=%b required=%b", k, tick, exp_tick);
      else n_pass++;
      if (k == 1) begin
        n_total++;
        if ((pin_rise | pin_fall) !== 32'h0) $display("FAIL release_strobes actual=%h/%h required=0", pin_rise, pin_fall);
        else n_pass++;
      end
    end
  endtask

  task automatic test_step();
    int   lat;
    int   nfall;
    int   nrise;
    int   bad;
    logic prev;
    for (int dir = 0; dir < 2; dir++) begin
      lat = 0; nfall = 0; nrise = 0; bad = 0;
      prev = pin_in[0];
      pin_raw[0] = (dir == 1);
      for (int n = 1; n <= 20; n++) begin
        step();
        if (lat == 0 && pin_in[0] == (dir == 1)) lat = n;
        if (pin_fall[0]) begin
          nfall++;
          if (!(prev == 1'b1 && pin_in[0] == 1'b0)) bad++;
        end
        if (pin_rise[0]) begin
          nrise++;
          if (!(prev == 1'b0 && pin_in[0] == 1'b1)) bad++;
        end
        prev = pin_in[0];
      end
      n_total++;
      if (lat < 11 || lat > 15) $display("FAIL step_latency dir=%0d actual=%0d required=11..15", dir, lat);
      else n_pass++;
      n_total++;
      if (nfall != (dir == 0 ? 1 : 0)) $display("FAIL step_fall_count dir=%0d actual=%0d required=%0d", dir, nfall, (dir == 0 ? 1 : 0));
      else n_pass++;
      n_total++;
      if (nrise != (dir == 1 ? 1 : 0)) $display("FAIL step_rise_count dir=%0d actual=%0d required=%0d", dir, nrise, (dir == 1 ? 1 : 0));
      else n_pass++;
      n_total++;
      if (bad != 0) $display("FAIL step_strobe_align dir=%0d actual=%0d misaligned required=0", dir, bad);
      else n_pass++;
      n_total++;
      if (pin_in[31:1] !== 31'h7FFF_FFFF) $display("FAIL step_other_pins actual=%h required=7fffffff", pin_in[31:1]);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    int nlow;
    int nstrobe;
    nlow = 0; nstrobe = 0;
    pin_raw[5] = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (n == 5) pin_raw[5] = 1'b1;
      if (pin_in[5] !== 1'b1) nlow++;
      if (pin_rise[5] || pin_fall[5]) nstrobe++;
    end
    n_total++;
    if (nlow != 0) $display("FAIL glitch_level actual=%0d low cycles required=0", nlow);
    else n_pass++;
    n_total++;
    if (nstrobe != 0) $display("FAIL glitch_strobe actual=%0d strobes required=0", nstrobe);
    else n_pass++;
  endtask

  task automatic test_bypass();
    logic val;
    logic exp_pin;
    int   nticks;
    bypass = 1'b1;
    repeat (2) step();
    val = 1'b1;
    nticks = 0;
    for (int t = 0; t < 4; t++) begin
      val = ~val;
      pin_raw[31] = val;
      for (int n = 1; n <= 10; n++) begin
        step();
        if (tick) nticks++;
        exp_pin = (n >= 3) ? val : ~val;
        n_total++;
        if (pin_in[31] !== exp_pin) $display("FAIL bypass_pin t=%0d n=%0d actual=%b required=%b", t, n, pin_in[31], exp_pin);
        else n_pass++;
        n_total++;
        if (pin_rise[31] !== (n == 3 && val)) $display("FAIL bypass_rise t=%0d n=%0d actual=%b required=%b", t, n, pin_rise[31], (n == 3 && val));
        else n_pass++;
        n_total++;
        if (pin_fall[31] !== (n == 3 && !val)) $display("FAIL bypass_fall t=%0d n=%0d actual=%b required=%b", t, n, pin_fall[31], (n == 3 && !val));
        else n_pass++;
      end
    end
    n_total++;
`ifdef GPIO_IN_FILTER_EN
    if (nticks != 10) $display("FAIL bypass_tick_count actual=%0d required=10", nticks);
    else n_pass++;
`else
    if (nticks != 0) $display("FAIL bypass_tick_count actual=%0d required=0", nticks);
    else n_pass++;
`endif
    bypass = 1'b0;
    repeat (5) step();
    n_total++;
    if (pin_in !== 32'hFFFF_FFFF) $display("FAIL bypass_exit actual=%h required=ffffffff", pin_in);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic exp_pin;
    pin_raw[9] = 1'b0;
    repeat (20) step();
    n_total++;
    if (pin_in[9] !== 1'b0) $display("FAIL mid_pre_pin9 actual=%b required=0", pin_in[9]);
    else n_pass++;
    pin_raw[3] = 1'b0;
    repeat (10) step();
    n_total++;
    if (pin_in[3] !== 1'b1) $display("FAIL mid_two_ticks_pin3 actual=%b required=1", pin_in[3]);
    else n_pass++;
    #1 resn = 1'b0;
    #1;
    n_total++;
    if (pin_in !== 32'hFFFF_FFFF) $display("FAIL mid_reset_pin_in actual=%h required=ffffffff", pin_in);
    else n_pass++;
    n_total++;
    if ((pin_rise | pin_fall) !== 32'h0 || tick !== 1'b0) $display("FAIL mid_reset_strobes actual=%h/%h/%b required=0", pin_rise, pin_fall, tick);
    else n_pass++;
    repeat (2) step();
    resn = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      exp_pin = (k >= 12) ? 1'b0 : 1'b1;
      n_total++;
      if (pin_in[3] !== exp_pin || pin_in[9] !== exp_pin) $display("FAIL mid_refilter k=%0d actual=%b%b required=%b%b", k, pin_in[3], pin_in[9], exp_pin, exp_pin);
      else n_pass++;
      n_total++;
      if (pin_fall[3] !== (k == 12) || pin_fall[9] !== (k == 12) || pin_rise !== 32'h0)
        $display("FAIL mid_strobe k=%0d actual=%b%b/%h required=%b%b/0", k, pin_fall[3], pin_fall[9], pin_rise, (k == 12), (k == 12));
      else n_pass++;
    end
    pin_raw = '1;
    repeat (20) step();
  endtask

  task automatic test_no_filter();
    logic val;
    logic exp_pin;
    val = 1'b1;
    for (int t = 0; t < 3; t++) begin
      val = ~val;
      bypass = t[0];
      pin_raw[7] = val;
      for (int n = 1; n <= 6; n++) begin
        step();
        exp_pin = (n >= 3) ? val : ~val;
        n_total++;
        if (pin_in[7] !== exp_pin) $display("FAIL nofilt_pin t=%0d n=%0d actual=%b required=%b", t, n, pin_in[7], exp_pin);
        else n_pass++;
        n_total++;
        if (pin_rise[7] !== (n == 3 && val) || pin_fall[7] !== (n == 3 && !val))
          $display("FAIL nofilt_strobe t=%0d n=%0d actual=%b/%b required=%b/%b", t, n, pin_rise[7], pin_fall[7], (n == 3 && val), (n == 3 && !val));
        else n_pass++;
        n_total++;
        if (tick !== 1'b0) $display("FAIL nofilt_tick t=%0d n=%0d actual=%b required=0", t, n, tick);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef GPIO_IN_FILTER_EN
    test_step();
    test_glitch();
    test_bypass();
    test_reset_mid();
`else
    test_bypass();
    test_no_filter();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
